snow64_instr_fetcher: RTL and testbench

Single-line instruction fetch buffer between the decode stage and the memory bus guard's instruction-read port. It holds one 32-byte line with its tag and answers 32-bit instruction fetches in one cycle on a hit. On a miss it issues a line read through the guard's req_read_instr port, then forwards the requested word the same cycle it fills the line. A flush input invalidates the line; a fill already in flight is completed and discarded.

---
 rtl/snow64_instr_fetcher_pkg.sv | 59 +++++
 rtl/snow64_instr_fetcher.sv | 141 ++++++++++++++
 tb/tb_snow64_instr_fetcher.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/snow64_instr_fetcher_pkg.sv
// ============================================================================
// PkgSnow64InstrFetcher : shared types and constants for the instruction fetcher
// Rev 1.0
// ============================================================================
`default_nettype none

package PkgSnow64InstrFetcher;

  localparam int unsigned CPU_ADDR_WIDTH = 64;
  localparam int unsigned LAR_DATA_WIDTH = 256;
  localparam int unsigned LINE_BYTES     = 32;
  localparam int unsigned WORD_IDX_WIDTH = 3;
  localparam int unsigned TAG_MSB        = 63;
  localparam int unsigned TAG_LSB        = 5;
  localparam int unsigned INSTR_WIDTH    = 32;
  localparam int unsigned TAG_WIDTH      = TAG_MSB - TAG_LSB + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } state_t;

  // Partial views of the memory bus guard's read port
  typedef struct packed {
    logic                      req;
    logic [CPU_ADDR_WIDTH-1:0] addr;
  } PartialPortOut_Guard_ReqRead;

  typedef struct packed {
    logic                      cmd_accepted;
    logic                      valid;
    logic [LAR_DATA_WIDTH-1:0] data;
  } PartialPortIn_Guard_ReqRead;

  typedef struct packed {
    logic                       fetch_req;
    logic [CPU_ADDR_WIDTH-1:0]  fetch_addr;
    logic                       flush;
    PartialPortIn_Guard_ReqRead req_read_instr;
  } PortIn_InstrFetcher;

  typedef struct packed {
    logic                        fetch_valid;
    logic [INSTR_WIDTH-1:0]      fetch_instr;
    logic                        busy;
    PartialPortOut_Guard_ReqRead req_read_instr;
  } PortOut_InstrFetcher;

  function automatic logic [INSTR_WIDTH-1:0] f_sel_word(
    input logic [LAR_DATA_WIDTH-1:0] line,
    input logic [WORD_IDX_WIDTH-1:0] idx
  );
    return line[INSTR_WIDTH*idx +: INSTR_WIDTH];
  endfunction

endpackage

`default_nettype wire

// File: rtl/snow64_instr_fetcher.sv
// ============================================================================
// snow64_instr_fetcher : single-line instruction fetch buffer in front of the
// memory bus guard's instruction-read port.
// Rev 1.0
// ============================================================================
`default_nettype none

module snow64_instr_fetcher
  import PkgSnow64InstrFetcher::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_fetch_req,
  input  logic [CPU_ADDR_WIDTH-1:0] in_fetch_addr,
  input  logic                      in_flush,
  output logic                      out_fetch_valid,
  output logic [INSTR_WIDTH-1:0]    out_fetch_instr,
  output logic                      out_busy,
  output logic                      out_req_read_instr_req,
  output logic [CPU_ADDR_WIDTH-1:0] out_req_read_instr_addr,
  input  logic                      in_req_read_instr_cmd_accepted,
  input  logic                      in_req_read_instr_valid,
  input  logic [LAR_DATA_WIDTH-1:0] in_req_read_instr_data
);

  PortIn_InstrFetcher  w_in;
  PortOut_InstrFetcher w_out;

  state_t                    r_state, w_state_nxt;
  logic                      r_line_valid, w_line_valid_nxt;
  logic                      r_drop, w_drop_nxt;
  logic [TAG_WIDTH-1:0]      r_tag, w_tag_nxt;
  logic [LAR_DATA_WIDTH-1:0] r_line, w_line_nxt;
  logic                      r_fetch_valid, w_fetch_valid_nxt;
  logic [INSTR_WIDTH-1:0]    r_fetch_instr, w_fetch_instr_nxt;
  logic [CPU_ADDR_WIDTH-1:0] r_req_addr, w_req_addr_nxt;

  logic [TAG_WIDTH-1:0]      w_addr_tag;
  logic [WORD_IDX_WIDTH-1:0] w_word_idx;
  logic                      w_hit;
  logic                      w_unused;

  always_comb begin
    w_in.fetch_req                   = in_fetch_req;
    w_in.fetch_addr                  = in_fetch_addr;
    w_in.flush                       = in_flush;
    w_in.req_read_instr.cmd_accepted = in_req_read_instr_cmd_accepted;
    w_in.req_read_instr.valid        = in_req_read_instr_valid;
    w_in.req_read_instr.data         = in_req_read_instr_data;
  end

  assign w_addr_tag = w_in.fetch_addr[TAG_MSB:TAG_LSB];
  assign w_word_idx = w_in.fetch_addr[TAG_LSB-1:2];
  assign w_hit      = r_line_valid && (r_tag == w_addr_tag) && !w_in.flush;
  assign w_unused   = ^w_in.fetch_addr[1:0];

  always_comb begin
    w_state_nxt       = r_state;
    w_line_valid_nxt  = r_line_valid && !w_in.flush;
    w_drop_nxt        = r_drop;
    w_tag_nxt         = r_tag;
    w_line_nxt        = r_line;
    w_fetch_valid_nxt = 1'b0;
    w_fetch_instr_nxt = r_fetch_instr;
    w_req_addr_nxt    = r_req_addr;

    case (r_state)
      StIdle: begin
        if (w_in.fetch_req) begin
          if (w_hit) begin
            w_fetch_valid_nxt = 1'b1;
            w_fetch_instr_nxt = f_sel_word(r_line, w_word_idx);
          end else begin
            w_req_addr_nxt = {w_addr_tag, {TAG_LSB{1'b0}}};
            w_state_nxt    = StReq;
          end
        end
      end
      StReq: begin
        if (w_in.flush) w_drop_nxt = 1'b1;
        if (w_in.req_read_instr.cmd_accepted) w_state_nxt = StWait;
      end
      StWait: begin
        if (w_in.flush) w_drop_nxt = 1'b1;
        if (w_in.req_read_instr.valid) begin
          // A flush on the very edge the data lands still discards it
          if (!r_drop && !w_in.flush) begin
            w_line_nxt        = w_in.req_read_instr.data;
            w_tag_nxt         = w_addr_tag;
            w_line_valid_nxt  = 1'b1;
            w_fetch_valid_nxt = 1'b1;
            w_fetch_instr_nxt = f_sel_word(w_in.req_read_instr.data, w_word_idx);
          end
          w_drop_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_line_valid  <= 1'b0;
      r_drop        <= 1'b0;
      r_tag         <= '0;
      r_line        <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_instr <= '0;
      r_req_addr    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_line_valid  <= w_line_valid_nxt;
      r_drop        <= w_drop_nxt;
      r_tag         <= w_tag_nxt;
      r_line        <= w_line_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_fetch_instr <= w_fetch_instr_nxt;
      r_req_addr    <= w_req_addr_nxt;
    end
  end

  // Request drops combinationally on accept so the guard never accepts twice
  always_comb begin
    w_out.fetch_valid         = r_fetch_valid;
    w_out.fetch_instr         = r_fetch_instr;
    w_out.busy                = (r_state != StIdle);
    w_out.req_read_instr.req  = (r_state == StReq) && !w_in.req_read_instr.cmd_accepted;
    w_out.req_read_instr.addr = r_req_addr;
  end

  assign out_fetch_valid         = w_out.fetch_valid;
  assign out_fetch_instr         = w_out.fetch_instr;
  assign out_busy                = w_out.busy;
  assign out_req_read_instr_req  = w_out.req_read_instr.req;
  assign out_req_read_instr_addr = w_out.req_read_instr.addr;

endmodule

`default_nettype wire

// File: tb/tb_snow64_instr_fetcher.sv
// ============================================================================
// tb_snow64_instr_fetcher : randomized bench with a line-level reference model
// and a behavioural guard responder.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_snow64_instr_fetcher;

  logic         clk, rst_n;
  logic         f_req, f_flush, acc, gval;
  logic [63:0]  f_addr;
  logic [255:0] gdata;
  logic         o_valid, o_busy, o_req;
  logic [31:0]  o_instr;
  logic [63:0]  o_raddr;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_busy, m_reqph, m_drop, m_valid, e_valid;
  logic [58:0] m_tag;
  logic [63:0] m_raddr;
  logic [31:0] e_instr;

  // guard responder state
  int          g_phase, g_stall, g_lat, g_reqs, g_accs;
  int          f_stall, f_lat;
  logic [63:0] g_addr;

  snow64_instr_fetcher dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .in_fetch_req                   (f_req),
    .in_fetch_addr                  (f_addr),
    .in_flush                       (f_flush),
    .out_fetch_valid                (o_valid),
    .out_fetch_instr                (o_instr),
    .out_busy                       (o_busy),
    .out_req_read_instr_req         (o_req),
    .out_req_read_instr_addr        (o_raddr),
    .in_req_read_instr_cmd_accepted (acc),
    .in_req_read_instr_valid        (gval),
    .in_req_read_instr_data         (gdata)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] wa;
    wa = {a[63:2], 2'b00};
    if (wa == 64'h1000) return 32'hDEADBEEF;
    return wa[31:0] ^ wa[63:32] ^ 32'hC0DE_0000 ^ {wa[9:2], 24'h0};
  endfunction

  function automatic logic [255:0] line_of(input logic [63:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word({a[63:5], 5'b0} + 64'(4*i));
    return l;
  endfunction

  function automatic logic [63:0] pick_addr();
    logic [63:0] b;
    case ($urandom_range(0, 3))
      0: b = 64'h1000;
      1: b = 64'h1020;
      2: b = 64'h2000;
      default: b = {$urandom, $urandom};
    endcase
    return {b[63:5], 5'b0} + 64'($urandom_range(0, 31));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_reqph = 0; m_drop = 0; m_valid = 0; e_valid = 0;
    m_tag = '0; m_raddr = '0; e_instr = '0; g_phase = 0;
  endtask

  // One clock: guard reacts to what it sees, model predicts, edge, compare.
  task automatic step();
    bit nxt;
    chk_eq("req", o_req, m_reqph);
    if (o_req) chk_eq("req_addr", o_raddr, m_raddr);
    acc = 0; gval = 0; gdata = {8{$urandom}};
    if (g_phase == 0 && o_req) begin
      g_phase = 1; g_reqs++; g_addr = o_raddr;
      g_stall = (f_stall >= 0) ? f_stall : $urandom_range(0, 3);
    end
    if (g_phase == 1) begin
      if (g_stall == 0) begin
        acc = 1; g_accs++; g_phase = 2;
        g_lat = (f_lat >= 0) ? f_lat : $urandom_range(0, 3);
      end else g_stall--;
    end else if (g_phase == 2) begin
      if (g_lat == 0) begin gval = 1; gdata = line_of(g_addr); g_phase = 0; end
      else g_lat--;
    end
    #1;
    if (acc) chk_eq("req_drop", o_req, 0);

    nxt = 0;
    if (m_busy) begin
      if (acc) m_reqph = 0;
      if (f_flush) m_drop = 1;
      if (gval) begin
        if (!m_drop) begin
          m_valid = 1; m_tag = f_addr[63:5]; nxt = 1; e_instr = mem_word(f_addr);
        end else m_valid = 0;
        m_busy = 0; m_drop = 0;
      end
    end else if (f_req) begin
      if (m_valid && m_tag == f_addr[63:5] && !f_flush) begin
        nxt = 1; e_instr = mem_word(f_addr);
      end else begin
        m_busy = 1; m_reqph = 1; m_drop = 0; m_raddr = {f_addr[63:5], 5'b0};
      end
    end
    if (f_flush) m_valid = 0;
    e_valid = nxt;

    @(posedge clk); #1;
    chk_eq("valid", o_valid, nxt);
    if (nxt) chk_eq("instr", o_instr, e_instr);
    chk_eq("busy", o_busy, m_busy);
  endtask

  task automatic fetch(input logic [63:0] a, input int max, output int edges);
    f_req = 1; f_addr = a; edges = 0;
    do begin step(); edges++; end while (!e_valid && edges < max);
    if (!e_valid) chk_eq("fetch_timeout", o_valid, 1);
  endtask

  initial begin
    int n, k, r0, a0;
    clk = 0; rst_n = 0; f_req = 0; f_addr = 0; f_flush = 0; acc = 0; gval = 0;
    gdata = '0; f_stall = -1; f_lat = -1; g_reqs = 0; g_accs = 0;
    model_reset();
    #12;
    chk_eq("rst_valid", o_valid, 0);
    chk_eq("rst_instr", o_instr, 0);
    chk_eq("rst_busy", o_busy, 0);
    chk_eq("rst_req", o_req, 0);
    chk_eq("rst_raddr", o_raddr, 0);
    @(posedge clk); #1; rst_n = 1;

    // cold miss with unstalled guard
    f_stall = 0; f_lat = 2;
    fetch(64'h1000, 20, n);
    chk_eq("miss_lat", n, 5);
    chk_eq("instr_1000", o_instr, 32'hDEADBEEF);

    // back-to-back hits on the same line
    r0 = g_reqs;
    for (int i = 1; i < 8; i++) fetch(64'h1000 + 64'(4*i), 1, n);
    chk_eq("hits_noreq", g_reqs, r0);

    fetch(64'h1020, 20, n);
    chk_eq("miss_1020_req", g_reqs, r0 + 1);
    fetch(64'h1000, 20, n);
    chk_eq("line_replaced", g_reqs, r0 + 2);

    // guard stall of 3 cycles
    f_stall = 3; f_lat = 0; r0 = g_reqs; a0 = g_accs;
    fetch(64'h2000, 20, n);
    chk_eq("stall_lat", n, 6);
    chk_eq("stall_reqs", g_reqs, r0 + 1);
    chk_eq("stall_accs", g_accs, a0 + 1);
    f_req = 0; step();

    // flush while waiting for the line
    f_stall = 0; f_lat = 3; r0 = g_reqs; f_req = 1; f_addr = 64'h3008;
    k = 0;
    do begin step(); k++; end while (g_phase != 2 && k < 10);
    chk_eq("flush_in_wait", o_busy, 1);
    f_flush = 1; step(); f_flush = 0;
    k = 0;
    while (!e_valid && k < 40) begin step(); k++; end
    chk_eq("flush_done", o_valid, 1);
    chk_eq("flush_rereq", g_reqs, r0 + 2);
    f_req = 0; step();

    // reset in the middle of a fill
    f_stall = 0; f_lat = 5; f_req = 1; f_addr = 64'h4000;
    k = 0;
    do begin step(); k++; end while (g_phase != 2 && k < 10);
    chk_eq("rst_in_wait", o_busy, 1);
    rst_n = 0; f_req = 0; acc = 0; gval = 0; #1;
    chk_eq("mrst_valid", o_valid, 0);
    chk_eq("mrst_instr", o_instr, 0);
    chk_eq("mrst_busy", o_busy, 0);
    chk_eq("mrst_req", o_req, 0);
    chk_eq("mrst_raddr", o_raddr, 0);
    model_reset();
    @(posedge clk); #1; rst_n = 1;
    gval = 1; acc = 1; gdata = line_of(64'h4000);
    @(posedge clk); #1;
    chk_eq("stray_valid", o_valid, 0);
    chk_eq("stray_busy", o_busy, 0);
    gval = 0; acc = 0;
    r0 = g_reqs;
    fetch(64'h4000, 20, n);
    chk_eq("post_rst_miss", g_reqs, r0 + 1);
    f_req = 0; step();

    // randomized traffic with flushes and guard stalls
    f_stall = -1; f_lat = -1;
    for (int c = 0; c < 3000; c++) begin
      if (!m_busy && (e_valid || !f_req)) begin
        f_req = ($urandom % 8) != 0;
        f_addr = pick_addr();
      end
      f_flush = ($urandom % 16) == 0;
      step();
    end
    f_req = 0; f_flush = 0;
    k = 0;
    while (m_busy && k < 20) begin step(); k++; end
    chk_eq("drain_idle", o_busy, 0);
    chk_eq("one_accept_per_req", g_accs, g_reqs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
